// File: rtl/m_keypadcon_if.sv
// Key-code bus between the keypad scanner and the MCU peripheral side.
// master: scanner drives data/valid/status; slave: MCU drives ack/clear.
interface m_keypadcon_if;
    logic [3:0] key_data;
    logic       key_valid;
    logic       key_ack;
    logic       key_pressed;
    logic       key_overflow;
    logic       ovf_clr;

    modport master (
        output key_data,
        output key_valid,
        output key_pressed,
        output key_overflow,
        input  key_ack,
        input  ovf_clr
    );

    modport slave (
        input  key_data,
        input  key_valid,
        input  key_pressed,
        input  key_overflow,
        output key_ack,
        output ovf_clr
    );
endinterface

// File: rtl/m_keypadcon.sv
// 4x4 matrix keypad scanner: row drive, column sync, frame debounce,
// single-key event detection and a key-code FIFO on the bus interface.
// Ports: clk, rst (sync, active-high), kp_col (active-low, async),
// kp_row (one-hot active-low), bus (m_keypadcon_if.master).
module m_keypadcon #(
    parameter int SCAN_DELAY     = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       kp_col,
    output logic [3:0]       kp_row,
    m_keypadcon_if.master    bus
);

    localparam int CW = $clog2(SCAN_DELAY);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] TC   = CW'(SCAN_DELAY - 1);
    localparam logic [SW-1:0] SMAX = SW'(DEBOUNCE_SCANS);
    localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);

    logic [3:0]    col_s1;
    logic [3:0]    col_s2;
    logic [CW-1:0] scan_cnt;
    logic [1:0]    row;
    logic [15:0]   frame;
    logic [15:0]   prev_frame;
    logic [SW-1:0] stable;
    logic [15:0]   deb;

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;

    logic [3:0]    sampled;
    logic          tc;
    logic          frame_done;
    logic [15:0]   full_frame;
    logic [SW-1:0] stable_n;
    logic          deb_load;
    logic          one_hot;
    logic          event_push;
    logic [3:0]    code;
    logic          pop;
    logic          push;
    logic          ovf_set;
    logic [AW-1:0] head_ptr;
    logic [3:0]    head_data;
    logic [AW:0]   count_n;

    always_comb begin
        sampled    = ~col_s2;
        tc         = (scan_cnt == TC);
        frame_done = tc && (row == 2'd3);
        // Row 3's sample is folded in the same cycle it is taken.
        full_frame = {sampled, frame[11:0]};

        if (full_frame != prev_frame) begin
            stable_n = SW'(1);
        end else if (stable == SMAX) begin
            stable_n = SMAX;
        end else begin
            stable_n = stable + SW'(1);
        end

        deb_load = frame_done && (stable_n == SMAX);
        one_hot  = (full_frame != 16'd0) &&
                   ((full_frame & (full_frame - 16'd1)) == 16'd0);
        // Only a 0 -> single-key transition counts; multi-key
        // states block events until everything is released.
        event_push = deb_load && one_hot && (deb == 16'd0);

        code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (full_frame[i]) begin
                code = 4'(i);
            end
        end

        pop     = bus.key_ack && bus.key_valid;
        push    = event_push && ((count != FULL) || pop);
        ovf_set = event_push && (count == FULL) && !pop;

        head_ptr = pop ? rptr + AW'(1) : rptr;
        // Bypass so a push into an emptying FIFO shows next cycle.
        if (push && (wptr == head_ptr)) begin
            head_data = code;
        end else begin
            head_data = mem[head_ptr];
        end

        unique case ({push, pop})
            2'b10:   count_n = count + (AW + 1)'(1);
            2'b01:   count_n = count - (AW + 1)'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_s1           <= 4'hF;
            col_s2           <= 4'hF;
            scan_cnt         <= '0;
            row              <= 2'd0;
            kp_row           <= 4'b1110;
            frame            <= '0;
            prev_frame       <= '0;
            stable           <= '0;
            deb              <= '0;
            wptr             <= '0;
            rptr             <= '0;
            count            <= '0;
            bus.key_data     <= 4'd0;
            bus.key_valid    <= 1'b0;
            bus.key_pressed  <= 1'b0;
            bus.key_overflow <= 1'b0;
        end else begin
            col_s1 <= kp_col;
            col_s2 <= col_s1;

            if (tc) begin
                scan_cnt        <= '0;
                frame[row*4 +: 4] <= sampled;
                row             <= row + 2'd1;
                kp_row          <= ~(4'b0001 << (row + 2'd1));
            end else begin
                scan_cnt <= scan_cnt + CW'(1);
            end

            if (frame_done) begin
                stable <= stable_n;
                if (full_frame != prev_frame) begin
                    prev_frame <= full_frame;
                end
            end

            if (deb_load) begin
                deb             <= full_frame;
                bus.key_pressed <= (full_frame != 16'd0);
            end

            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= head_ptr;
            end
            count         <= count_n;
            bus.key_valid <= (count_n != '0);
            bus.key_data  <= head_data;

            if (ovf_set) begin
                bus.key_overflow <= 1'b1;
            end else if (bus.ovf_clr) begin
                bus.key_overflow <= 1'b0;
            end
        end
    end

endmodule
